// File: rtl/w8_pkg.sv
// ----------------------------------------------------------------------------
// w8_pkg
// Shared constants and types for the w8 weight buffer.
//   DW         : weight width (signed bytes)
//   AW         : per-bank address width
//   DEPTH      : entries per bank
//   NBANK      : number of read banks serving w8
//   WBUF_WORDS : total bytes in one full load (NBANK * DEPTH)
//   state_t    : loader FSM state encoding
// ----------------------------------------------------------------------------
package w8_pkg;

    localparam int DW         = 8;
    localparam int AW         = 4;
    localparam int DEPTH      = 1 << AW;
    localparam int NBANK      = 16;
    localparam int WBUF_WORDS = NBANK * DEPTH;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/w8_wbuf_bank.sv
// ----------------------------------------------------------------------------
// w8_wbuf_bank
// One DEPTH x DW bank: single write port, single synchronous read port.
// A read and a write to the same address in one cycle return the old data.
// Ports:
//   clk    : clock, rising edge
//   xrst   : asynchronous active-low reset (clears rdata only)
//   we     : write enable
//   waddr  : write address
//   wdata  : signed write data
//   raddr  : read address
//   rdata  : signed registered read data, one cycle after raddr
// ----------------------------------------------------------------------------
module w8_wbuf_bank #(
    parameter int DW = w8_pkg::DW,
    parameter int AW = w8_pkg::AW
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] mem [1 << AW];

    // Storage is intentionally not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/w8_wbuf.sv
// ----------------------------------------------------------------------------
// w8_wbuf
// Weight buffer for the w8 compute block. A bank-major byte stream
// (16 banks x 16 signed bytes) is loaded over a valid/ready handshake;
// each of the 16 banks answers its own read address with one-cycle latency.
// Optional feature macro: W8_WBUF_CKSUM_EN (16-bit load checksum).
// Ports:
//   clk, xrst            : clock and asynchronous active-low reset
//   load_start           : pulse in IDLE starts a 256-byte load
//   s_valid/s_ready      : stream handshake; s_data is the signed byte
//   load_busy            : high while loading
//   load_done            : one-cycle pulse after the last byte is written
//   load_cksum           : checksum of last completed load (0 if disabled)
//   wK_raddr / wK_rdata  : per-bank read address / registered read data
// ----------------------------------------------------------------------------
module w8_wbuf #(
    parameter int DW = w8_pkg::DW,
    parameter int AW = w8_pkg::AW
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 load_start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 load_busy,
    output logic                 load_done,
    output logic [15:0]          load_cksum,
    input  logic [AW-1:0]        w0_raddr,  w1_raddr,  w2_raddr,  w3_raddr,
    input  logic [AW-1:0]        w4_raddr,  w5_raddr,  w6_raddr,  w7_raddr,
    input  logic [AW-1:0]        w8_raddr,  w9_raddr,  w10_raddr, w11_raddr,
    input  logic [AW-1:0]        w12_raddr, w13_raddr, w14_raddr, w15_raddr,
    output logic signed [DW-1:0] w0_rdata,  w1_rdata,  w2_rdata,  w3_rdata,
    output logic signed [DW-1:0] w4_rdata,  w5_rdata,  w6_rdata,  w7_rdata,
    output logic signed [DW-1:0] w8_rdata,  w9_rdata,  w10_rdata, w11_rdata,
    output logic signed [DW-1:0] w12_rdata, w13_rdata, w14_rdata, w15_rdata
);
    import w8_pkg::*;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               start_acc;
    logic               last_acc;
    logic [NBANK-1:0]   we_a;
    logic [AW-1:0]      raddr_a [NBANK];
    logic signed [DW-1:0] rdata_a [NBANK];

    assign accept    = s_valid && s_ready;
    assign start_acc = (state == IDLE) && load_start;
    assign last_acc  = accept && (cnt == CNT_W'(WBUF_WORDS - 1));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;  // wraps to 0 after the final byte
            end
        end
    end

    // Handshake outputs decode the registered state only, never s_valid.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready   = 1'b1;
                load_busy = 1'b1;
                if (last_acc) state_nxt = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef W8_WBUF_CKSUM_EN
    function automatic logic [15:0] sext16(input logic signed [DW-1:0] d);
        return 16'(d);
    endfunction

    logic [15:0] cksum_acc;

    // The published value is taken on the final accept so it is valid
    // in the same cycle load_done is high.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cksum_acc  <= '0;
            load_cksum <= '0;
        end else begin
            if (start_acc) begin
                cksum_acc <= '0;
            end else if (accept) begin
                cksum_acc <= cksum_acc + sext16(s_data);
            end
            if (last_acc) begin
                load_cksum <= cksum_acc + sext16(s_data);
            end
        end
    end
`else
    assign load_cksum = '0;
`endif

    assign raddr_a[0]  = w0_raddr;   assign raddr_a[1]  = w1_raddr;
    assign raddr_a[2]  = w2_raddr;   assign raddr_a[3]  = w3_raddr;
    assign raddr_a[4]  = w4_raddr;   assign raddr_a[5]  = w5_raddr;
    assign raddr_a[6]  = w6_raddr;   assign raddr_a[7]  = w7_raddr;
    assign raddr_a[8]  = w8_raddr;   assign raddr_a[9]  = w9_raddr;
    assign raddr_a[10] = w10_raddr;  assign raddr_a[11] = w11_raddr;
    assign raddr_a[12] = w12_raddr;  assign raddr_a[13] = w13_raddr;
    assign raddr_a[14] = w14_raddr;  assign raddr_a[15] = w15_raddr;

    assign w0_rdata  = rdata_a[0];   assign w1_rdata  = rdata_a[1];
    assign w2_rdata  = rdata_a[2];   assign w3_rdata  = rdata_a[3];
    assign w4_rdata  = rdata_a[4];   assign w5_rdata  = rdata_a[5];
    assign w6_rdata  = rdata_a[6];   assign w7_rdata  = rdata_a[7];
    assign w8_rdata  = rdata_a[8];   assign w9_rdata  = rdata_a[9];
    assign w10_rdata = rdata_a[10];  assign w11_rdata = rdata_a[11];
    assign w12_rdata = rdata_a[12];  assign w13_rdata = rdata_a[13];
    assign w14_rdata = rdata_a[14];  assign w15_rdata = rdata_a[15];

    // Bank-major stream: upper counter nibble picks the bank, lower the entry.
    for (genvar k = 0; k < NBANK; k++) begin : g_bank
        assign we_a[k] = accept && (cnt[7:4] == 4'(k));

        w8_wbuf_bank #(.DW(DW), .AW(AW)) u_bank (
            .clk   (clk),
            .xrst  (xrst),
            .we    (we_a[k]),
            .waddr (cnt[AW-1:0]),
            .wdata (s_data),
            .raddr (raddr_a[k]),
            .rdata (rdata_a[k])
        );
    end

endmodule

// File: tb/tb_w8_wbuf.sv
module tb_w8_wbuf;

    logic              clk = 1'b0;
    logic              xrst;
    logic              load_start;
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_data;
    logic              load_busy;
    logic              load_done;
    logic [15:0]       load_cksum;
    logic [3:0]        raddr [16];
    logic signed [7:0] rdata [16];

    int n_assert = 0;
    int n_fail   = 0;
    logic signed [7:0] cap_old, cap_new;

`ifdef W8_WBUF_CKSUM_EN
    localparam logic [15:0] EXP_CK_IDX = 16'hFF80;
    localparam logic [15:0] EXP_CK_FF  = 16'hFF00;
`else
    localparam logic [15:0] EXP_CK_IDX = 16'h0000;
    localparam logic [15:0] EXP_CK_FF  = 16'h0000;
`endif

`define CHK(obs, exp, tag) \
    begin \
        n_assert++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
        end \
    end

    always #5 clk = ~clk;

    w8_wbuf dut (
        .clk        (clk),
        .xrst       (xrst),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_cksum (load_cksum),
        .w0_raddr  (raddr[0]),  .w1_raddr  (raddr[1]),
        .w2_raddr  (raddr[2]),  .w3_raddr  (raddr[3]),
        .w4_raddr  (raddr[4]),  .w5_raddr  (raddr[5]),
        .w6_raddr  (raddr[6]),  .w7_raddr  (raddr[7]),
        .w8_raddr  (raddr[8]),  .w9_raddr  (raddr[9]),
        .w10_raddr (raddr[10]), .w11_raddr (raddr[11]),
        .w12_raddr (raddr[12]), .w13_raddr (raddr[13]),
        .w14_raddr (raddr[14]), .w15_raddr (raddr[15]),
        .w0_rdata  (rdata[0]),  .w1_rdata  (rdata[1]),
        .w2_rdata  (rdata[2]),  .w3_rdata  (rdata[3]),
        .w4_rdata  (rdata[4]),  .w5_rdata  (rdata[5]),
        .w6_rdata  (rdata[6]),  .w7_rdata  (rdata[7]),
        .w8_rdata  (rdata[8]),  .w9_rdata  (rdata[9]),
        .w10_rdata (rdata[10]), .w11_rdata (rdata[11]),
        .w12_rdata (rdata[12]), .w13_rdata (rdata[13]),
        .w14_rdata (rdata[14]), .w15_rdata (rdata[15])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: index; 1: all 0xFF; 2: index but byte 36 = 0x11; 3: index but byte 36 = 0x7F
    function automatic logic signed [7:0] byte_val(input int kind, input int idx);
        case (kind)
            0:       return 8'(idx);
            1:       return 8'shFF;
            2:       return (idx == 36) ? 8'sh11 : 8'(idx);
            default: return (idx == 36) ? 8'sh7F : 8'(idx);
        endcase
    endfunction

    // Starts a load and streams bytes until n_bytes have been accepted.
    // Returns at the sample point just after the last accept edge.
    task automatic run_load(input int kind, input bit gaps, input int n_bytes, input string tag);
        int  idx, cyc, early, stall_err;
        bit  acc;
        idx = 0; cyc = 0; early = 0; stall_err = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (idx < n_bytes && cyc < 2000) begin
            s_valid    = gaps ? ((cyc % 3) != 2) : 1'b1;
            s_data     = byte_val(kind, idx);
            load_start = (idx == 50);
            acc        = s_valid && s_ready;
            tick();
            cyc++;
            if (acc) idx++;
            if (acc && idx == 37) cap_old = rdata[2];
            if (acc && idx == 38) cap_new = rdata[2];
            if (dut.cnt !== 8'(idx)) stall_err++;
            if (idx < 256 && load_done !== 1'b0) early++;
        end
        s_valid    = 1'b0;
        load_start = 1'b0;
        `CHK(idx, n_bytes, {tag, "_accepts"})
        `CHK(stall_err, 0, {tag, "_cnt_track"})
        `CHK(early, 0, {tag, "_early_done"})
        if (n_bytes == 256) begin
            `CHK(load_done, 1'b1, {tag, "_load_done"})
        end
    endtask

    task automatic rd(input int b, input logic [3:0] a, input logic signed [7:0] e, input string tag);
        raddr[b] = a;
        tick();
        `CHK(rdata[b], e, tag)
    endtask

    initial begin
        xrst       = 1'b0;
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        for (int b = 0; b < 16; b++) raddr[b] = 4'($urandom_range(0, 15));
        tick(); tick(); tick();

        // Reset state
        for (int b = 0; b < 16; b++) `CHK(rdata[b], 8'sh00, "rst_rdata")
        `CHK(s_ready, 1'b0, "rst_s_ready")
        `CHK(load_busy, 1'b0, "rst_load_busy")
        `CHK(load_done, 1'b0, "rst_load_done")
        `CHK(load_cksum, 16'h0000, "rst_cksum")
        xrst = 1'b1;
        tick();
        `CHK(s_ready, 1'b0, "idle_s_ready")
        `CHK(load_done, 1'b0, "idle_load_done")

        // Full continuous load, value = index
        run_load(0, 1'b0, 256, "full");
        `CHK(load_cksum, EXP_CK_IDX, "full_cksum")
        tick();
        `CHK(load_done, 1'b0, "full_done_pulse")
        `CHK(s_ready, 1'b0, "full_idle_ready")
        rd(3, 4'd5, 8'sh35, "full_w3_5");
        rd(15, 4'd15, -8'sd1, "full_w15_15");
        rd(0, 4'd0, 8'sh00, "full_w0_0");

        // Load with gaps every 3rd cycle, load_start pulsed mid-load; byte 36 = 0x11
        run_load(2, 1'b1, 256, "gaps");
        tick();
        rd(3, 4'd5, 8'sh35, "gaps_w3_5");
        rd(15, 4'd15, -8'sd1, "gaps_w15_15");
        rd(2, 4'd4, 8'sh11, "gaps_w2_4");
        rd(9, 4'd10, 8'sh9A, "gaps_w9_10");

        // Read-during-write on bank 2 address 4
        raddr[2] = 4'd4;
        tick();
        run_load(3, 1'b0, 256, "rdw");
        `CHK(cap_old, 8'sh11, "rdw_old")
        `CHK(cap_new, 8'sh7F, "rdw_new")

        // Reset mid-load after 100 accepts of 0xFF
        tick();
        run_load(1, 1'b0, 100, "abort");
        xrst = 1'b0;
        #1;
        `CHK(s_ready, 1'b0, "abort_s_ready")
        `CHK(load_busy, 1'b0, "abort_busy")
        `CHK(load_done, 1'b0, "abort_done")
        tick();
        xrst = 1'b1;
        tick();
        `CHK(s_ready, 1'b0, "abort_idle_ready")
        `CHK(load_done, 1'b0, "abort_no_done")
        `CHK(load_cksum, 16'h0000, "abort_cksum")
        rd(0, 4'd0, -8'sd1, "abort_w0_0");
        rd(6, 4'd3, -8'sd1, "abort_w6_3");
        rd(6, 4'd4, 8'sh64, "abort_w6_4");
        rd(9, 4'd9, 8'sh99, "abort_w9_9");

        // Complete load of all 0xFF; checksum, and load_start during DONE ignored
        run_load(1, 1'b0, 256, "ff");
        `CHK(load_cksum, EXP_CK_FF, "ff_cksum")
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        `CHK(s_ready, 1'b0, "done_start_ignored")
        `CHK(load_cksum, EXP_CK_FF, "ff_cksum_hold")
        tick();
        `CHK(s_ready, 1'b0, "done_start_still_idle")
        `CHK(load_busy, 1'b0, "done_start_not_busy")
        rd(6, 4'd4, -8'sd1, "ff_w6_4");
        rd(2, 4'd4, -8'sd1, "ff_w2_4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
